// File: rtl/rbb_wr_arbiter_pkg.sv
// Shared types and width helpers for the result-batch-buffer write arbiter.
package rbb_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } arb_state_e;

    localparam int N_RBB_DEF   = 4;
    localparam int LINE_AW_DEF = 8;
    localparam int DATA_W_DEF  = 512;
    localparam int HOST_AW_DEF = 32;
    localparam int RING_W_DEF  = 4;

    // Buffer index width; never below one bit.
    function automatic int idw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rbb_wr_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
module rbb_wr_arbiter_rr_pick
    import rbb_wr_arbiter_pkg::*;
#(
    parameter int N_RBB = N_RBB_DEF,
    parameter int IDW   = idw_f(N_RBB)
) (
    input  logic [N_RBB-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [IDW-1:0]   gnt_idx,
    output logic             any
);

    int j;

    // Walk from the farthest offset down so the nearest one wins.
    always_comb begin
        gnt_idx = '0;
        j       = 0;
        for (int i = N_RBB - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N_RBB) begin
                j = j - N_RBB;
            end
            if (req[j]) begin
                gnt_idx = IDW'(j);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rbb_wr_arbiter.sv
// Shares one host write channel among N_RBB result batch buffers,
// draining one whole batch per grant through a registered write stage.
module rbb_wr_arbiter
    import rbb_wr_arbiter_pkg::*;
#(
    parameter int N_RBB   = N_RBB_DEF,
    parameter int LINE_AW = LINE_AW_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int HOST_AW = HOST_AW_DEF,
    parameter int RING_W  = RING_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [HOST_AW-1:0]         res_base,
    input  logic [N_RBB-1:0]           req_valid,
    input  logic [N_RBB*LINE_AW-1:0]   req_line_idx,
    input  logic [N_RBB*DATA_W-1:0]    rd_dout,
    output logic [N_RBB-1:0]           req_ack,
    output logic                       wr_valid,
    output logic [HOST_AW-1:0]         wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_ready,
    output logic                       batch_done,
    output logic [idw_f(N_RBB)-1:0]    batch_done_id,
    output logic [RING_W-1:0]          batch_seq,
    output logic                       busy,
    output logic                       seq_err
);

    localparam int IDW = idw_f(N_RBB);

    arb_state_e         state_q, state_d;
    logic [IDW-1:0]     g_q, g_d;
    logic [HOST_AW-1:0] base_q, base_d;
    logic [LINE_AW-1:0] line_cnt_q, line_cnt_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic               wr_valid_q, wr_valid_d;
    logic [HOST_AW-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               batch_done_q, batch_done_d;
    logic [IDW-1:0]     batch_done_id_q, batch_done_id_d;
    logic [RING_W-1:0]  batch_seq_q, batch_seq_d;
    logic               seq_err_q, seq_err_d;

    logic [LINE_AW-1:0] sel_idx;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_req;
    logic               load;
    logic [IDW-1:0]     rr_next;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;

    rbb_wr_arbiter_rr_pick #(
        .N_RBB (N_RBB),
        .IDW   (IDW)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // A load may refill the output stage in the same cycle it drains.
    always_comb begin
        sel_idx  = req_line_idx[int'(g_q)*LINE_AW +: LINE_AW];
        sel_data = rd_dout[int'(g_q)*DATA_W +: DATA_W];
        sel_req  = req_valid[g_q];
        load     = (state_q == ST_STREAM) && sel_req &&
                   (!wr_valid_q || wr_ready);
        rr_next  = (int'(g_q) == N_RBB - 1) ? '0 : g_q + IDW'(1);
    end

    always_comb begin
        req_ack      = '0;
        req_ack[g_q] = load;
    end

    always_comb begin
        state_d         = state_q;
        g_d             = g_q;
        base_d          = base_q;
        line_cnt_d      = line_cnt_q;
        rr_ptr_d        = rr_ptr_q;
        wr_valid_d      = wr_valid_q && !wr_ready;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        batch_done_d    = 1'b0;
        batch_done_id_d = batch_done_id_q;
        batch_seq_d     = batch_seq_q;
        seq_err_d       = seq_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (enable && pick_any) begin
                    g_d        = pick_idx;
                    base_d     = res_base;
                    line_cnt_d = '0;
                    state_d    = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (load) begin
                    wr_valid_d = 1'b1;
                    wr_data_d  = sel_data;
                    wr_addr_d  = base_q +
                                 HOST_AW'({batch_seq_q, line_cnt_q});
                    if (sel_idx != line_cnt_q) begin
                        seq_err_d = 1'b1;
                    end
                    line_cnt_d = line_cnt_q + LINE_AW'(1);
                    if (line_cnt_q == '1) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (!wr_valid_q || wr_ready) begin
                    batch_done_d    = 1'b1;
                    batch_done_id_d = g_q;
                    batch_seq_d     = batch_seq_q + RING_W'(1);
                    rr_ptr_d        = rr_next;
                    state_d         = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            g_q             <= '0;
            base_q          <= '0;
            line_cnt_q      <= '0;
            rr_ptr_q        <= '0;
            wr_valid_q      <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            batch_done_q    <= 1'b0;
            batch_done_id_q <= '0;
            batch_seq_q     <= '0;
            seq_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            g_q             <= g_d;
            base_q          <= base_d;
            line_cnt_q      <= line_cnt_d;
            rr_ptr_q        <= rr_ptr_d;
            wr_valid_q      <= wr_valid_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            batch_done_q    <= batch_done_d;
            batch_done_id_q <= batch_done_id_d;
            batch_seq_q     <= batch_seq_d;
            seq_err_q       <= seq_err_d;
        end
    end

    assign wr_valid      = wr_valid_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign batch_done    = batch_done_q;
    assign batch_done_id = batch_done_id_q;
    assign batch_seq     = batch_seq_q;
    assign seq_err       = seq_err_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rbb_wr_arbiter.sv
// Directed bench for rbb_wr_arbiter with small behavioural buffer models.
module tb_rbb_wr_arbiter;

    localparam int N   = 4;
    localparam int LAW = 2;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int RW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              enable;
    logic [AW-1:0]     res_base;
    logic [N-1:0]      req_valid;
    logic [N*LAW-1:0]  req_line_idx;
    logic [N*DW-1:0]   rd_dout;
    logic [N-1:0]      req_ack;
    logic              wr_valid;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              wr_ready;
    logic              batch_done;
    logic [1:0]        batch_done_id;
    logic [RW-1:0]     batch_seq;
    logic              busy;
    logic              seq_err;

    logic [LAW-1:0]    idx_bump;
    logic [LAW-1:0]    bline [N];
    logic [AW-1:0]     q_addr [$];
    logic [DW-1:0]     q_data [$];
    int                total = 0;
    int                bad   = 0;

    typedef struct {
        logic [3:0]  mask;
        int          id;
        logic [31:0] addr;
        int          seq;
    } bvec_t;

    typedef struct {
        logic [3:0]  ack;
        logic        wv;
        logic [31:0] addr;
        logic        bd;
    } s1_t;

    bvec_t vec [9];
    s1_t   s1 [6];
    bit    rdy_pat [12];

    rbb_wr_arbiter #(
        .N_RBB   (N),
        .LINE_AW (LAW),
        .DATA_W  (DW),
        .HOST_AW (AW),
        .RING_W  (RW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .res_base      (res_base),
        .req_valid     (req_valid),
        .req_line_idx  (req_line_idx),
        .rd_dout       (rd_dout),
        .req_ack       (req_ack),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .batch_done    (batch_done),
        .batch_done_id (batch_done_id),
        .batch_seq     (batch_seq),
        .busy          (busy),
        .seq_err       (seq_err)
    );

    // Buffer model: presents the next line the cycle after each ack.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!reset_n) bline[i] <= '0;
            else if (req_ack[i]) bline[i] <= bline[i] + 2'd1;
        end
    end

    always_comb begin
        req_line_idx = '0;
        rd_dout      = '0;
        for (int i = 0; i < N; i++) begin
            req_line_idx[i*LAW +: LAW] =
                bline[i] + ((bline[i] == 2'd2) ? idx_bump : 2'd0);
            rd_dout[i*DW +: DW] = {8'hD0 + 8'(i), 8'h00, 14'h0, bline[i]};
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (wr_valid && wr_ready) begin
                q_addr.push_back(wr_addr);
                q_data.push_back(wr_data);
            end
            chk("ack_onehot", 64'($countones(req_ack) <= 1), 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic post_checks(input int id, input logic [31:0] addr,
                               input int seq);
        chk("batch_done", batch_done, 1);
        chk("done_id", batch_done_id, 64'(id));
        chk("batch_seq", batch_seq, 64'(seq));
        chk("beat_count", q_addr.size(), 4);
        for (int j = 0; j < 4 && j < q_addr.size(); j++) begin
            chk("beat_addr", q_addr[j], addr + j);
            chk("beat_data", q_data[j], {8'hD0 + 8'(id), 8'h00, 16'(j)});
        end
    endtask

    task automatic run_batch(input logic [3:0] mask, input int id,
                             input logic [31:0] addr, input int seq);
        int n;
        q_addr.delete();
        q_data.delete();
        req_valid = mask;
        n = 0;
        do begin
            tick();
            n++;
        end while (!batch_done && n < 40);
        req_valid = '0;
        post_checks(id, addr, seq);
    endtask

    initial begin
        int n;
        int nacks;
        logic stalled;
        logic [AW-1:0] hold_a;
        logic [DW-1:0] hold_d;

        vec[0] = '{4'hF, 0, 32'h1000, 1};
        vec[1] = '{4'hF, 1, 32'h1004, 2};
        vec[2] = '{4'hF, 2, 32'h1008, 3};
        vec[3] = '{4'hF, 3, 32'h100C, 4};
        vec[4] = '{4'hF, 0, 32'h1010, 5};
        vec[5] = '{4'h9, 3, 32'h1014, 6};
        vec[6] = '{4'h6, 1, 32'h1018, 7};
        vec[7] = '{4'h2, 1, 32'h101C, 8};
        vec[8] = '{4'h5, 2, 32'h1020, 9};

        s1[0] = '{4'h2, 1'b0, 32'h0,    1'b0};
        s1[1] = '{4'h2, 1'b1, 32'h1000, 1'b0};
        s1[2] = '{4'h2, 1'b1, 32'h1001, 1'b0};
        s1[3] = '{4'h2, 1'b1, 32'h1002, 1'b0};
        s1[4] = '{4'h0, 1'b1, 32'h1003, 1'b0};
        s1[5] = '{4'h0, 1'b0, 32'h0,    1'b1};

        rdy_pat = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};

        reset_n   = 1'b0;
        enable    = 1'b1;
        wr_ready  = 1'b1;
        res_base  = 32'h1000;
        req_valid = '0;
        idx_bump  = '0;
        repeat (3) tick();

        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_req_ack", req_ack, 0);
        chk("rst_batch_done", batch_done, 0);
        chk("rst_done_id", batch_done_id, 0);
        chk("rst_batch_seq", batch_seq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_seq_err", seq_err, 0);
        reset_n = 1'b1;
        tick();

        // Single buffer, cycle-exact
        q_addr.delete();
        q_data.delete();
        req_valid = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t1_ack", req_ack, s1[k].ack);
            chk("t1_wr_valid", wr_valid, s1[k].wv);
            if (s1[k].wv) chk("t1_wr_addr", wr_addr, s1[k].addr);
            chk("t1_done", batch_done, s1[k].bd);
        end
        req_valid = '0;
        post_checks(1, 32'h1000, 1);

        // Round-robin table from a fresh reset
        do_reset();
        for (int r = 0; r < 9; r++) begin
            run_batch(vec[r].mask, vec[r].id, vec[r].addr, vec[r].seq);
        end

        // Host back-pressure mid-batch
        q_addr.delete();
        q_data.delete();
        req_valid = 4'b0001;
        stalled = 1'b0;
        hold_a = '0;
        hold_d = '0;
        n = 0;
        do begin
            tick();
            n++;
            wr_ready = (n < 12) ? rdy_pat[n] : 1'b1;
            #1;
            if (stalled) begin
                chk("stall_addr_hold", wr_addr, hold_a);
                chk("stall_data_hold", wr_data, hold_d);
            end
            stalled = wr_valid && !wr_ready;
            if (stalled) begin
                chk("stall_no_ack", req_ack, 0);
                hold_a = wr_addr;
                hold_d = wr_data;
            end
        end while (!batch_done && n < 40);
        wr_ready  = 1'b1;
        req_valid = '0;
        post_checks(0, 32'h1024, 10);

        // Line index skip: 0,1,3
        q_addr.delete();
        q_data.delete();
        idx_bump = 2'd1;
        req_valid = 4'b0010;
        n = 0;
        nacks = 0;
        do begin
            tick();
            n++;
            chk("seq_err_track", seq_err, 64'(nacks >= 3));
            if (req_ack != '0) nacks++;
        end while (!batch_done && n < 40);
        req_valid = '0;
        idx_bump  = '0;
        post_checks(1, 32'h1028, 11);
        run_batch(4'b0100, 2, 32'h102C, 12);
        chk("seq_err_sticky", seq_err, 1);
        do_reset();
        chk("seq_err_cleared", seq_err, 0);

        // Sequence wrap over 17 batches
        for (int k = 0; k < 17; k++) begin
            run_batch(4'b0100, 2, 32'h1000 + 32'(4 * (k % 16)), (k + 1) % 16);
        end

        // Reset while line 2 is being loaded
        req_valid = 4'b0001;
        n = 0;
        nacks = 0;
        do begin
            tick();
            n++;
            if (req_ack[0]) nacks++;
        end while (nacks < 3 && n < 20);
        chk("mid_ack_seen", 64'(nacks), 3);
        reset_n = 1'b0;
        tick();
        chk("mid_wr_valid", wr_valid, 0);
        chk("mid_wr_addr", wr_addr, 0);
        chk("mid_wr_data", wr_data, 0);
        chk("mid_req_ack", req_ack, 0);
        chk("mid_batch_done", batch_done, 0);
        chk("mid_done_id", batch_done_id, 0);
        chk("mid_batch_seq", batch_seq, 0);
        chk("mid_busy", busy, 0);
        chk("mid_seq_err", seq_err, 0);
        tick();
        reset_n   = 1'b1;
        enable    = 1'b0;
        req_valid = 4'hF;
        repeat (4) begin
            tick();
            chk("dis_busy", busy, 0);
            chk("dis_ack", req_ack, 0);
            chk("dis_done", batch_done, 0);
        end
        enable = 1'b1;
        run_batch(4'hF, 0, 32'h1000, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
